div_unit: RTL and testbench

Iterative 32-bit integer divider that executes DIV/DIVU for the EX stage. EX raises `start` with operands held stable; the unit drives `stall` while it works and pulses `done` with the 64-bit {HI, LO} result destined for the hilo register write. It replaces single-cycle division inside the ALU with a fixed-latency radix-2 restoring datapath.

---
 rtl/div_unit_pkg.sv | 36 +++
 rtl/div_step.sv | 43 ++++
 rtl/div_unit.sv | 183 ++++++++++++++++++
 tb/tb_div_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
//
// Shared CPU definitions for the iterative divider:
//   - state encodings for the divide FSM (plain localparams plus an enum built
//     from them, so older code comparing raw 3-bit codes stays compatible)
//   - DIV_STEPS : number of restoring iterations per divide
//   - HILO_W    : width of the packed {HI, LO} result
//   - negIf()   : conditional two's-complement negation used for sign handling
// -----------------------------------------------------------------------------
package div_unit_pkg;

    localparam int DIV_STEPS = 32;
    localparam int HILO_W    = 64;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_CALC = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        PREP = ST_PREP,
        CALC = ST_CALC,
        FIX  = ST_FIX,
        DONE = ST_DONE
    } div_state_t;

    // Negate v when neg is set. Also serves as abs() when neg is the sign bit:
    // abs(0x8000_0000) stays 0x8000_0000, which is the correct unsigned magnitude.
    function automatic logic [31:0] negIf(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//
// One radix-2 restoring division iteration, purely combinational.
//
// Ports:
//   rem      in  WIDTH+1  partial remainder before this step
//   quo      in  WIDTH    quotient shift register (unconsumed dividend bits
//                         at the top, developed quotient bits at the bottom)
//   divisor  in  WIDTH    divisor magnitude
//   remNext  out WIDTH+1  partial remainder after this step
//   quoNext  out WIDTH    quotient register after this step
// -----------------------------------------------------------------------------
module div_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   remNext,
    output logic [WIDTH-1:0] quoNext
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             fits;

    // Shift {rem, quo} left by one: the next dividend bit enters the remainder.
    assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};

    // Trial subtraction with one extra bit to expose the borrow.
    assign trial = {1'b0, shifted} - {2'b00, divisor};

    // If the bit shifted out of rem was set, the shifted value is at least
    // 2^(WIDTH+1) and always exceeds the divisor, whatever the borrow says.
    assign fits = rem[WIDTH] | ~trial[WIDTH+1];

    assign remNext = fits ? trial[WIDTH:0] : shifted;
    assign quoNext = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//
// Iterative 32-bit DIV/DIVU unit for the EX stage. A request accepted in IDLE
// runs PREP (magnitudes), 32 CALC cycles (one restoring step each), FIX (sign
// correction, result registration) and DONE (one-cycle done pulse). Latency
// from start to done is a fixed 35 cycles, including divide-by-zero.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   rst        in   1       asynchronous active-low reset
//   start      in   1       divide request, sampled in IDLE only
//   is_signed  in   1       1 = DIV (two's complement), 0 = DIVU
//   dividend   in   WIDTH   numerator, sampled with start
//   divisor    in   WIDTH   denominator, sampled with start
//   cancel     in   1       synchronous abort (exception / flush)
//   stall      out  1       combinational pipeline hold while a divide is pending
//   done       out  1       registered one-cycle completion pulse
//   div_zero   out  1       registered, valid with done: divisor was zero
//   hilo       out  2*WIDTH {HI = remainder, LO = quotient}, held between results
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               cancel,
    output logic               stall,
    output logic               done,
    output logic               div_zero,
    output logic [2*WIDTH-1:0] hilo
);

    localparam int              CNT_W    = $clog2(DIV_STEPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // FSM
    div_state_t stateReg;
    div_state_t stateNext;

    // Request captured in IDLE
    logic             signedReg;
    logic             zeroReg;
    logic [WIDTH-1:0] dividendReg;
    logic [WIDTH-1:0] divisorReg;

    // Iteration datapath
    logic             qNegReg;
    logic             rNegReg;
    logic [WIDTH:0]   remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] divMagReg;
    logic [CNT_W-1:0] countReg;

    // Outputs
    logic               doneReg;
    logic               divZeroReg;
    logic [2*WIDTH-1:0] hiloReg;

    // Single restoring step
    logic [WIDTH:0]   remNext;
    logic [WIDTH-1:0] quoNext;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem     (remReg),
        .quo     (quoReg),
        .divisor (divMagReg),
        .remNext (remNext),
        .quoNext (quoNext)
    );

    // -------------------------------------------------------------------------
    // Next-state logic. cancel overrides everything; in IDLE it also blocks a
    // simultaneous start. DONE ignores start and always returns to IDLE.
    // -------------------------------------------------------------------------
    always_comb begin
        stateNext = stateReg;
        if (cancel) begin
            stateNext = IDLE;
        end else begin
            case (stateReg)
                IDLE:    if (start) stateNext = PREP;
                PREP:    stateNext = CALC;
                CALC:    if (countReg == '0) stateNext = FIX;
                FIX:     stateNext = DONE;
                DONE:    stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State and datapath registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg    <= IDLE;
            signedReg   <= 1'b0;
            zeroReg     <= 1'b0;
            dividendReg <= '0;
            divisorReg  <= '0;
            qNegReg     <= 1'b0;
            rNegReg     <= 1'b0;
            remReg      <= '0;
            quoReg      <= '0;
            divMagReg   <= '0;
            countReg    <= '0;
            doneReg     <= 1'b0;
            divZeroReg  <= 1'b0;
            hiloReg     <= '0;
        end else begin
            stateReg <= stateNext;
            doneReg  <= 1'b0;

            // A cancelled cycle performs no datapath work; in FIX this means
            // the result is dropped and hilo/div_zero keep their old values.
            if (!cancel) begin
                case (stateReg)
                    IDLE: begin
                        if (start) begin
                            signedReg   <= is_signed;
                            dividendReg <= dividend;
                            divisorReg  <= divisor;
                            zeroReg     <= (divisor == '0);
                        end
                    end

                    PREP: begin
                        divMagReg <= negIf(divisorReg, signedReg & divisorReg[WIDTH-1]);
                        quoReg    <= negIf(dividendReg, signedReg & dividendReg[WIDTH-1]);
                        remReg    <= '0;
                        countReg  <= CNT_LAST;
                        qNegReg   <= signedReg & (dividendReg[WIDTH-1] ^ divisorReg[WIDTH-1]);
                        rNegReg   <= signedReg & dividendReg[WIDTH-1];
                    end

                    CALC: begin
                        remReg   <= remNext;
                        quoReg   <= quoNext;
                        countReg <= countReg - CNT_ONE;
                    end

                    FIX: begin
                        doneReg    <= 1'b1;
                        divZeroReg <= zeroReg;
                        // Divide-by-zero bypasses sign fixing entirely: the
                        // quotient reads all ones and HI returns the raw dividend.
                        if (zeroReg) begin
                            hiloReg <= {dividendReg, {WIDTH{1'b1}}};
                        end else begin
                            hiloReg <= {negIf(remReg[WIDTH-1:0], rNegReg),
                                        negIf(quoReg, qNegReg)};
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign stall = ((stateReg == IDLE) && start && !cancel) ||
                   (stateReg == PREP) ||
                   (stateReg == CALC) ||
                   (stateReg == FIX);

    assign done     = doneReg;
    assign div_zero = divZeroReg;
    assign hilo     = hiloReg;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//
// Table-driven bench for div_unit: a vector table of DIV/DIVU operands with
// hand-computed {HI, LO}, div_zero and fixed timing, applied back to back,
// followed by hand-written sequences for cancel, asynchronous reset mid-divide
// and start held through DONE. Inputs are driven and outputs sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        stall;
    logic        done;
    logic        div_zero;
    logic [63:0] hilo;

    always #5 clk = ~clk;

    div_unit #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .cancel    (cancel),
        .stall     (stall),
        .done      (done),
        .div_zero  (div_zero),
        .hilo      (hilo)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        logic        expZero;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    // Start a divide at the current falling edge (caller is positioned in an
    // IDLE cycle = cycle 0) and run until done or a cycle budget expires.
    task automatic doDivide(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                            input bit holdStart,
                            output logic [63:0] res, output logic zero,
                            output int lat, output int stallCycles, output logic stallAtDone);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        #1;
        check("stall_cycle0", stall, 1'b1);
        lat         = 0;
        stallCycles = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (stall) stallCycles++;
        end
        res         = hilo;
        zero        = div_zero;
        stallAtDone = stall;
        if (holdStart) begin
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    logic [63:0] res;
    logic        zero;
    int          lat;
    int          stallCycles;
    logic        stallAtDone;
    logic [63:0] prior;
    int          doneSeen;
    int          stallSeen;

    initial begin
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  1'b0};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001,  32'hFFFF_FFFD,  1'b0};
        vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000,  1'b0};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'h0,          32'hFFFF_FFFF,  1'b0};
        vecs[5]  = '{1'b0, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1'b1};
        vecs[6]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd14,         1'b0};
        vecs[7]  = '{1'b0, 32'h8000_0000,  32'd3,          32'd2,          32'h2AAA_AAAA,  1'b0};
        vecs[8]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  32'hFFFF_FFFF,  1'b1};
        vecs[9]  = '{1'b0, 32'hFFFF_FFFF,  32'd2,          32'd1,          32'h7FFF_FFFF,  1'b0};
        vecs[10] = '{1'b1, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  32'h0,          1'b0};

        // ---- reset state ----
        #2;
        check("reset_stall", stall, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_div_zero", div_zero, 1'b0);
        check("reset_hilo", hilo, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // ---- vector table, back to back ----
        for (int i = 0; i < NVEC; i++) begin
            doDivide(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b0, res, zero, lat, stallCycles, stallAtDone);
            check($sformatf("vec%0d_latency", i), lat, 35);
            check($sformatf("vec%0d_stall_cycles", i), stallCycles, 34);
            check($sformatf("vec%0d_stall_done", i), stallAtDone, 1'b0);
            check($sformatf("vec%0d_hilo", i), res, {vecs[i].expHi, vecs[i].expLo});
            check($sformatf("vec%0d_div_zero", i), zero, vecs[i].expZero);
            $display("[TB] %s 0x%08h / 0x%08h -> hilo=0x%016h div_zero=%0b latency=%0d",
                     vecs[i].sgn ? "DIV " : "DIVU", vecs[i].a, vecs[i].b, res, zero, lat);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), done, 1'b0);
            check($sformatf("vec%0d_hilo_held", i), hilo, {vecs[i].expHi, vecs[i].expLo});
        end

        // ---- cancel together with start in IDLE: not accepted ----
        start = 1'b1; cancel = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
        #1;
        check("idle_cancel_stall", stall, 1'b0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        #1;
        check("idle_cancel_not_accepted", stall, 1'b0);
        $display("[TB] start+cancel in IDLE -> stall=%0b", stall);

        // ---- cancel at cycle 10 of a divide ----
        prior = hilo;
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        for (int c = 1; c <= 10; c++) @(negedge clk);
        cancel = 1'b1; start = 1'b0;
        #1;
        check("cancel_cycle10_stall", stall, 1'b1);
        @(negedge clk);
        cancel = 1'b0;
        #1;
        check("cancel_cycle11_stall", stall, 1'b0);
        check("cancel_cycle11_done", done, 1'b0);
        check("cancel_hilo_kept", hilo, prior);
        $display("[TB] cancel at cycle 10 -> stall=%0b hilo=0x%016h", stall, hilo);
        @(negedge clk);
        doDivide(1'b1, 32'd9, 32'd0, 1'b0, res, zero, lat, stallCycles, stallAtDone);
        check("after_cancel_latency", lat, 35);
        check("after_cancel_hilo", res, {32'd9, 32'hFFFF_FFFF});
        check("after_cancel_div_zero", zero, 1'b1);
        $display("[TB] DIV  9 / 0 after cancel -> hilo=0x%016h div_zero=%0b latency=%0d", res, zero, lat);

        // ---- asynchronous reset at cycle 20 ----
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'hFFFF_0000; divisor = 32'h10;
        for (int c = 1; c <= 20; c++) @(negedge clk);
        #2;
        rst = 1'b0; start = 1'b0;
        #1;
        check("midreset_hilo", hilo, 64'h0);
        check("midreset_done", done, 1'b0);
        check("midreset_stall", stall, 1'b0);
        check("midreset_div_zero", div_zero, 1'b0);
        $display("[TB] reset at cycle 20 -> hilo=0x%016h stall=%0b", hilo, stall);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // ---- fresh divide with start held through DONE ----
        doDivide(1'b0, 32'd1000, 32'd10, 1'b1, res, zero, lat, stallCycles, stallAtDone);
        check("post_reset_latency", lat, 35);
        check("post_reset_hilo", res, {32'd0, 32'd100});
        check("post_reset_div_zero", zero, 1'b0);
        $display("[TB] DIVU 1000 / 10 start held -> hilo=0x%016h latency=%0d", res, lat);
        doneSeen  = 0;
        stallSeen = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (done)  doneSeen++;
            if (stall) stallSeen++;
            @(negedge clk);
        end
        check("held_start_no_retrigger_stall", stallSeen, 0);
        check("held_start_no_retrigger_done", doneSeen, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
